// File: rtl/riscp_pkg.sv
// Shared register-file types: index and word widths, register count, zero-register index.
package riscp_pkg;
    localparam int ADDR_W  = 3;
    localparam int DATA_W  = 16;
    localparam int REG_NUM = 1 << ADDR_W;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] reg_word_t;

    localparam reg_idx_t REG_ZERO = 3'd0;
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending bits: set on issue, cleared on writeback, issue wins on a collision.
// Latency: busy/pend_vec are combinational from the state; state updates on the next edge.
module reg_scoreboard
    import riscp_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               issue_en,
    input  reg_idx_t           issue_addr,
    input  logic               wr_en,
    input  reg_idx_t           wr_addr,
    input  reg_idx_t           rd_addr_a,
    input  reg_idx_t           rd_addr_b,
    output logic [REG_NUM-1:0] pend_vec,
    output logic               busy_a,
    output logic               busy_b
);
    // R0 has no pending flop at all, so it can never read back as busy.
    logic [REG_NUM-1:1] pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            for (int i = 1; i < REG_NUM; i++) begin
                if (issue_en && issue_addr == reg_idx_t'(i))
                    pending[i] <= 1'b1;
                else if (wr_en && wr_addr == reg_idx_t'(i))
                    pending[i] <= 1'b0;
            end
        end
    end

    assign pend_vec = {pending, 1'b0};
    assign busy_a   = pend_vec[rd_addr_a];
    assign busy_b   = pend_vec[rd_addr_b];
endmodule

// File: rtl/reg_file_3addr.sv
// 8x16 register file, two async read ports, one sync write port, RAW scoreboard.
// Optional same-cycle write-to-read forwarding under macro REGFILE_BYPASS_EN.
module reg_file_3addr
    import riscp_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  rd_addr_a,
    output logic [DATA_W-1:0]  rd_data_a,
    output logic               busy_a,
    input  logic [ADDR_W-1:0]  rd_addr_b,
    output logic [DATA_W-1:0]  rd_data_b,
    output logic               busy_b,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic               issue_en,
    input  logic [ADDR_W-1:0]  issue_addr,
    output logic [REG_NUM-1:0] pend_vec
);
    reg_word_t regs [REG_NUM-1:1];
    reg_word_t stored_a, stored_b;
    logic      sb_busy_a, sb_busy_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < REG_NUM; i++) regs[i] <= '0;
        end else if (wr_en && wr_addr != REG_ZERO) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign stored_a = (rd_addr_a == REG_ZERO) ? '0 : regs[rd_addr_a];
    assign stored_b = (rd_addr_b == REG_ZERO) ? '0 : regs[rd_addr_b];

    reg_scoreboard u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .pend_vec   (pend_vec),
        .busy_a     (sb_busy_a),
        .busy_b     (sb_busy_b)
    );

`ifdef REGFILE_BYPASS_EN
    logic fwd_a, fwd_b;

    // Forwarding is gated by rst_n so outputs still read zero while reset is held.
    assign fwd_a = rst_n && wr_en && wr_addr == rd_addr_a && rd_addr_a != REG_ZERO;
    assign fwd_b = rst_n && wr_en && wr_addr == rd_addr_b && rd_addr_b != REG_ZERO;

    // A same-cycle issue to the forwarded index is a newer producer, so it stays busy.
    assign rd_data_a = fwd_a ? wr_data : stored_a;
    assign rd_data_b = fwd_b ? wr_data : stored_b;
    assign busy_a    = fwd_a ? (issue_en && issue_addr == rd_addr_a) : sb_busy_a;
    assign busy_b    = fwd_b ? (issue_en && issue_addr == rd_addr_b) : sb_busy_b;
`else
    assign rd_data_a = stored_a;
    assign rd_data_b = stored_b;
    assign busy_a    = sb_busy_a;
    assign busy_b    = sb_busy_b;
`endif
endmodule

// File: tb/tb_reg_file_3addr.sv
// Directed-vector bench for reg_file_3addr; expectations follow REGFILE_BYPASS_EN when defined.
module tb_reg_file_3addr;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  rd_addr_a, rd_addr_b, wr_addr, issue_addr;
    logic [15:0] rd_data_a, rd_data_b, wr_data;
    logic        busy_a, busy_b, wr_en, issue_en;
    logic [7:0]  pend_vec;

    int n_vec = 0;
    int n_bad = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    always #5 clk = ~clk;

    reg_file_3addr dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr_a  (rd_addr_a),
        .rd_data_a  (rd_data_a),
        .busy_a     (busy_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_b  (rd_data_b),
        .busy_b     (busy_b),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .pend_vec   (pend_vec)
    );

    typedef struct {
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic        ie;
        logic [2:0]  ia;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [15:0] ea;
        logic [15:0] eb;
        logic        eba;
        logic        ebb;
        logic [7:0]  ep;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(logic we, logic [2:0] wa, logic [15:0] wd,
                                logic ie, logic [2:0] ia, logic [2:0] ra, logic [2:0] rb,
                                logic [15:0] ea, logic [15:0] eb, logic eba, logic ebb,
                                logic [7:0] ep);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ia = ia; v.ra = ra; v.rb = rb;
        v.ea = ea; v.eb = eb; v.eba = eba; v.ebb = ebb; v.ep = ep;
        return v;
    endfunction

    task automatic check(input string name, input logic [41:0] got, input logic [41:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got da=%h db=%h ba=%b bb=%b pend=%h, want da=%h db=%h ba=%b bb=%b pend=%h",
                     name, got[41:26], got[25:10], got[9], got[8], got[7:0],
                     exp[41:26], exp[25:10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    function automatic logic [41:0] outs();
        return {rd_data_a, rd_data_b, busy_a, busy_b, pend_vec};
    endfunction

    initial begin
        // Outputs are checked before each edge; the row's writes/issues land at that edge.
        //             we wa  wd       ie ia  ra  rb  exp_a                  exp_b                  ba        bb pend
        tbl[0]  = mk(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000,              16'h0000,              0,        0, 8'h00);
        tbl[1]  = mk(1, 3, 16'hBEEF, 0, 0, 3, 3, BYP ? 16'hBEEF : 16'h0, BYP ? 16'hBEEF : 16'h0, 0,        0, 8'h00);
        tbl[2]  = mk(1, 0, 16'h1234, 0, 0, 3, 3, 16'hBEEF,              16'hBEEF,              0,        0, 8'h00);
        tbl[3]  = mk(0, 0, 16'h0000, 0, 0, 0, 3, 16'h0000,              16'hBEEF,              0,        0, 8'h00);
        tbl[4]  = mk(0, 0, 16'h0000, 1, 5, 5, 3, 16'h0000,              16'hBEEF,              0,        0, 8'h00);
        tbl[5]  = mk(1, 5, 16'h0042, 0, 0, 5, 0, BYP ? 16'h0042 : 16'h0, 16'h0000,              !BYP,     0, 8'h20);
        tbl[6]  = mk(0, 0, 16'h0000, 0, 0, 5, 5, 16'h0042,              16'h0042,              0,        0, 8'h00);
        tbl[7]  = mk(1, 2, 16'h0007, 1, 2, 2, 5, BYP ? 16'h0007 : 16'h0, 16'h0042,              BYP,      0, 8'h00);
        tbl[8]  = mk(0, 0, 16'h0000, 0, 0, 2, 2, 16'h0007,              16'h0007,              1,        1, 8'h04);
        tbl[9]  = mk(0, 0, 16'h0000, 1, 2, 2, 2, 16'h0007,              16'h0007,              1,        1, 8'h04);
        tbl[10] = mk(1, 2, 16'h0009, 0, 0, 2, 2, BYP ? 16'h0009 : 16'h7, BYP ? 16'h0009 : 16'h7, !BYP,    !BYP, 8'h04);
        tbl[11] = mk(0, 0, 16'h0000, 0, 0, 2, 2, 16'h0009,              16'h0009,              0,        0, 8'h00);
        tbl[12] = mk(1, 4, 16'h1111, 0, 0, 4, 0, BYP ? 16'h1111 : 16'h0, 16'h0000,              0,        0, 8'h00);
        tbl[13] = mk(1, 3, 16'hCAFE, 1, 1, 4, 3, 16'h1111,              BYP ? 16'hCAFE : 16'hBEEF, 0,     0, 8'h00);
        tbl[14] = mk(0, 0, 16'h0000, 0, 0, 1, 3, 16'h0000,              16'hCAFE,              1,        0, 8'h02);
        tbl[15] = mk(1, 6, 16'hA5A5, 0, 0, 1, 6, 16'h0000,              BYP ? 16'hA5A5 : 16'h0, 1,        0, 8'h02);
        tbl[16] = mk(0, 0, 16'h0000, 1, 0, 0, 6, 16'h0000,              16'hA5A5,              0,        0, 8'h02);
        tbl[17] = mk(0, 0, 16'h0000, 1, 7, 0, 0, 16'h0000,              16'h0000,              0,        0, 8'h02);
        tbl[18] = mk(1, 1, 16'h0001, 0, 0, 7, 0, 16'h0000,              16'h0000,              1,        0, 8'h82);
        tbl[19] = mk(0, 0, 16'h0000, 0, 0, 7, 1, 16'h0000,              16'h0001,              1,        0, 8'h80);

        rst_n = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        issue_en = 1'b0; issue_addr = '0;
        rd_addr_a = '0; rd_addr_b = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
            issue_en = tbl[i].ie; issue_addr = tbl[i].ia;
            rd_addr_a = tbl[i].ra; rd_addr_b = tbl[i].rb;
            #1;
            check($sformatf("vec%0d", i), outs(),
                  {tbl[i].ea, tbl[i].eb, tbl[i].eba, tbl[i].ebb, tbl[i].ep});
            @(negedge clk);
        end

        // Mid-cycle reset must clear storage and scoreboard without waiting for an edge.
        wr_en = 1'b0; issue_en = 1'b0;
        rd_addr_a = 3; rd_addr_b = 7;
        #1;
        check("pre_reset", outs(), {16'hCAFE, 16'h0000, 1'b0, 1'b1, 8'h80});
        #1 rst_n = 1'b0;
        #1;
        check("async_reset", outs(), {16'h0000, 16'h0000, 1'b0, 1'b0, 8'h00});

        // A write presented while reset is held is dropped.
        wr_en = 1'b1; wr_addr = 4; wr_data = 16'hFFFF; rd_addr_a = 4;
        @(negedge clk);
        rst_n = 1'b1; wr_en = 1'b0;
        #1;
        check("write_in_reset", outs(), {16'h0000, 16'h0000, 1'b0, 1'b0, 8'h00});

        wr_en = 1'b1; wr_data = 16'h1357;
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        check("write_after_reset", outs(), {16'h1357, 16'h0000, 1'b0, 1'b0, 8'h00});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
